// File: rtl/uart_handler_pkg.sv
// Shared definitions for the UART input/output handler pair: character
// constants used by the ASCII front end and the common state encoding.
package uart_handler_pkg;

  localparam logic [7:0] CHAR_L       = 8'h4C;
  localparam logic [7:0] CHAR_0       = 8'h30;
  localparam logic [7:0] CHAR_A_UPPER = 8'h41;
  localparam logic [7:0] CHAR_A_LOWER = 8'h61;

  // Number of hex characters in each fixed-size field of a frame
  localparam logic [3:0] COUNT_NIBBLES   = 4'd4;
  localparam logic [3:0] COMMAND_NIBBLES = 4'd4;
  localparam logic [3:0] ADDRESS_NIBBLES = 4'd8;
  localparam logic [3:0] DATA_NIBBLES    = 4'd8;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    READ_COUNT   = 3'd1,
    READ_COMMAND = 3'd2,
    READ_ADDRESS = 3'd3,
    READ_DATA    = 3'd4
  } state_t;

endpackage

// File: rtl/uart_input_handler_if.sv
// Byte stream in from the UART receiver and parsed frame fields out to the
// wishbone master handler. 'byte' is a reserved word, so the received
// character is carried on rx_byte.
interface uart_input_handler_if;

  logic [7:0]  rx_byte;
  logic        byte_available;
  logic [15:0] command;
  logic [31:0] address;
  logic [31:0] data;
  logic [15:0] data_count;
  logic        command_en;
  logic        data_en;
  logic        finished;
  logic        error;
  logic        busy;

  // Byte source side (UART receiver / testbench)
  modport master (
    output rx_byte, byte_available,
    input  command, address, data, data_count,
    input  command_en, data_en, finished, error, busy
  );

  // Parser side (uart_input_handler)
  modport slave (
    input  rx_byte, byte_available,
    output command, address, data, data_count,
    output command_en, data_en, finished, error, busy
  );

endinterface

// File: rtl/uart_input_handler_ascii_hex_decoder.sv
// Combinational ASCII hex character decoder: reports whether the character
// is a legal hex digit (either letter case) and its 4-bit value.
module ascii_hex_decoder
  import uart_handler_pkg::*;
(
  input  logic [7:0] ch,
  output logic       legal,
  output logic [3:0] nibble
);

  // Classify the character into digit / upper / lower hex ranges
  always_comb begin
    legal  = 1'b0;
    nibble = 4'h0;
    if (ch >= CHAR_0 && ch <= CHAR_0 + 8'd9) begin
      legal  = 1'b1;
      nibble = 4'(ch - CHAR_0);
    end else if (ch >= CHAR_A_UPPER && ch <= CHAR_A_UPPER + 8'd5) begin
      legal  = 1'b1;
      nibble = 4'(ch - CHAR_A_UPPER + 8'd10);
    end else if (ch >= CHAR_A_LOWER && ch <= CHAR_A_LOWER + 8'd5) begin
      legal  = 1'b1;
      nibble = 4'(ch - CHAR_A_LOWER + 8'd10);
    end
  end

endmodule

// File: rtl/uart_input_handler.sv
// Parses 'L' framed hex commands from the UART receiver into command,
// address, data_count and a stream of 32-bit data words, with single-cycle
// strobes for the wishbone master handler. Illegal characters and mid-frame
// silence abort the frame with an error pulse.
module uart_input_handler
  import uart_handler_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32'd1_000_000
) (
  input logic                clk,
  input logic                rst,
  uart_input_handler_if.slave bus
);

  localparam int TIMER_W = $clog2(TIMEOUT) + 1;

  state_t             state;
  logic [3:0]         nib_cnt;
  logic [15:0]        remaining;
  logic [TIMER_W-1:0] timer;
  logic               first_word;
  logic [31:0]        data_acc;

  logic [15:0] command;
  logic [31:0] address;
  logic [31:0] data;
  logic [15:0] data_count;
  logic        command_en;
  logic        data_en;
  logic        finished;
  logic        error;

  logic       legal;
  logic [3:0] nibble;
  logic       timeout_hit;

  ascii_hex_decoder u_decoder (
    .ch     (bus.rx_byte),
    .legal  (legal),
    .nibble (nibble)
  );

  // The abort fires on the edge where the idle count reaches TIMEOUT-1; an
  // arriving byte always takes precedence over expiry.
  assign timeout_hit = (state != IDLE) && !bus.byte_available &&
                       (timer + 1'b1 == TIMER_W'(TIMEOUT - 32'd1));

  // Idle-cycle counter, only running while a frame is in progress
  always_ff @(posedge clk) begin
    if (rst || bus.byte_available || state == IDLE || timeout_hit) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Frame parser FSM with registered fields and strobes
  always_ff @(posedge clk) begin
    command_en <= 1'b0;
    data_en    <= 1'b0;
    finished   <= 1'b0;
    error      <= 1'b0;
    if (rst) begin
      state      <= IDLE;
      nib_cnt    <= 4'd0;
      remaining  <= 16'd0;
      first_word <= 1'b0;
      data_acc   <= 32'd0;
      command    <= 16'd0;
      address    <= 32'd0;
      data       <= 32'd0;
      data_count <= 16'd0;
    end else if (bus.byte_available) begin
      if (state == IDLE) begin
        if (bus.rx_byte == CHAR_L) begin
          nib_cnt <= 4'd0;
          state   <= READ_COUNT;
        end
      end else if (!legal) begin
        error   <= 1'b1;
        nib_cnt <= 4'd0;
        state   <= IDLE;
      end else begin
        nib_cnt <= nib_cnt + 4'd1;
        case (state)
          READ_COUNT: begin
            data_count <= {data_count[11:0], nibble};
            if (nib_cnt == COUNT_NIBBLES - 4'd1) begin
              nib_cnt <= 4'd0;
              state   <= READ_COMMAND;
            end
          end
          READ_COMMAND: begin
            command <= {command[11:0], nibble};
            if (nib_cnt == COMMAND_NIBBLES - 4'd1) begin
              nib_cnt <= 4'd0;
              state   <= READ_ADDRESS;
            end
          end
          READ_ADDRESS: begin
            address <= {address[27:0], nibble};
            if (nib_cnt == ADDRESS_NIBBLES - 4'd1) begin
              nib_cnt    <= 4'd0;
              remaining  <= data_count;
              first_word <= 1'b1;
              data_acc   <= 32'd0;
              state      <= READ_DATA;
            end
          end
          READ_DATA: begin
            data_acc <= {data_acc[27:0], nibble};
            if (nib_cnt == DATA_NIBBLES - 4'd1) begin
              nib_cnt    <= 4'd0;
              data       <= {data_acc[27:0], nibble};
              data_en    <= 1'b1;
              command_en <= first_word;
              first_word <= 1'b0;
              if (remaining != 16'd0) begin
                remaining <= remaining - 16'd1;
                data_acc  <= 32'd0;
              end else begin
                finished <= 1'b1;
                state    <= IDLE;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end else if (timeout_hit) begin
      error   <= 1'b1;
      nib_cnt <= 4'd0;
      state   <= IDLE;
    end
  end

  assign bus.command    = command;
  assign bus.address    = address;
  assign bus.data       = data;
  assign bus.data_count = data_count;
  assign bus.command_en = command_en;
  assign bus.data_en    = data_en;
  assign bus.finished   = finished;
  assign bus.error      = error;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_input_handler.sv
// Testbench for uart_input_handler: feeds ASCII frames, predicts each data
// word into a scoreboard and checks the DUT's strobes and fields against it.
module tb_uart_input_handler;

  typedef struct {
    logic [31:0] data;
    logic [15:0] command;
    logic [31:0] address;
    logic [15:0] data_count;
    logic        first;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;

  uart_input_handler_if bus ();

  uart_input_handler #(.TIMEOUT(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  exp_t        mon_e;
  int          check_count;
  int          pass_count;
  int          err_seen;
  logic [31:0] word_buf [0:3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] hexChar(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  // One idle cycle, then a one-cycle strobe; returns just after the sampling edge
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_byte        = b;
    bus.byte_available = 1'b1;
    @(posedge clk); #1;
    bus.byte_available = 1'b0;
  endtask

  task automatic sendString(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
  endtask

  task automatic sendField(input logic [31:0] value, input int nibbles, input bit lower);
    for (int i = nibbles - 1; i >= 0; i--) applyStimulus(hexChar(value[i*4 +: 4], lower));
  endtask

  // Predict every word of the frame, then transmit it
  task automatic sendFrame(input logic [15:0] cnt, input logic [15:0] cmd,
                           input logic [31:0] addr, input bit lower);
    exp_t e;
    for (int i = 0; i <= int'(cnt); i++) begin
      e.data       = word_buf[i];
      e.command    = cmd;
      e.address    = addr;
      e.data_count = cnt;
      e.first      = (i == 0);
      e.last       = (i == int'(cnt));
      sb.push_back(e);
    end
    applyStimulus(8'h4C);
    sendField({16'h0, cnt}, 4, lower);
    sendField({16'h0, cmd}, 4, lower);
    sendField(addr, 8, lower);
    for (int i = 0; i <= int'(cnt); i++) sendField(word_buf[i], 8, lower);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare every data_en against the scoreboard, count error pulses
  initial begin
    forever begin
      @(negedge clk);
      if (bus.data_en) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_data_en", 64'(bus.data_en), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("data",       64'(bus.data),       64'(mon_e.data));
          checkOutput("command",    64'(bus.command),    64'(mon_e.command));
          checkOutput("address",    64'(bus.address),    64'(mon_e.address));
          checkOutput("data_count", 64'(bus.data_count), 64'(mon_e.data_count));
          checkOutput("command_en", 64'(bus.command_en), 64'(mon_e.first));
          checkOutput("finished",   64'(bus.finished),   64'(mon_e.last));
        end
      end else if (bus.command_en || bus.finished) begin
        checkOutput("stray_strobe", {62'd0, bus.command_en, bus.finished}, 64'd0);
      end
      if (bus.error) err_seen++;
    end
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    int err_before;
    check_count = 0;
    pass_count  = 0;
    err_seen    = 0;
    rst = 1'b1;
    bus.rx_byte = 8'h00;
    bus.byte_available = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_command",    64'(bus.command),    64'd0);
    checkOutput("rst_address",    64'(bus.address),    64'd0);
    checkOutput("rst_data",       64'(bus.data),       64'd0);
    checkOutput("rst_data_count", 64'(bus.data_count), 64'd0);
    checkOutput("rst_strobes", {60'd0, bus.command_en, bus.data_en, bus.finished, bus.error}, 64'd0);
    checkOutput("rst_busy",       64'(bus.busy),       64'd0);

    $display("[TB] single-word frame");
    word_buf[0] = 32'hDEADBEEF;
    sendFrame(16'h0000, 16'h0001, 32'h12345678, 1'b0);

    $display("[TB] three-word frame, lowercase hex");
    word_buf[0] = 32'h00000001;
    word_buf[1] = 32'h0000000A;
    word_buf[2] = 32'hFFFFFFFF;
    sendFrame(16'h0002, 16'h0002, 32'h00000010, 1'b1);

    $display("[TB] idle noise then frame");
    err_before = err_seen;
    sendString("xyz");
    applyStimulus(8'h0D);
    applyStimulus(8'h0A);
    @(posedge clk); #1;
    checkOutput("noise_no_error", 64'(err_seen - err_before), 64'd0);
    checkOutput("noise_not_busy", 64'(bus.busy), 64'd0);
    word_buf[0] = 32'hCAFE0123;
    word_buf[1] = 32'h89ABCDEF;
    sendFrame(16'h0001, 16'hABCD, 32'h40001000, 1'b0);

    $display("[TB] illegal character mid-frame");
    sendString("L00000001123");
    checkOutput("busy_before_bad", 64'(bus.busy), 64'd1);
    applyStimulus("G");
    checkOutput("bad_char_error",   64'(bus.error),   64'd1);
    checkOutput("bad_char_busy",    64'(bus.busy),    64'd0);
    checkOutput("bad_char_data_en", 64'(bus.data_en), 64'd0);
    word_buf[0] = 32'h55AA55AA;
    sendFrame(16'h0000, 16'h0003, 32'h0000FFFC, 1'b0);

    $display("[TB] mid-frame timeout");
    sendString("L0000");
    k = 1;
    while (k <= 200) begin
      @(posedge clk); #1;
      if (bus.error) break;
      k++;
    end
    checkOutput("timeout_cycles", 64'(k), 64'd99);
    checkOutput("timeout_busy",   64'(bus.busy), 64'd0);

    $display("[TB] reset mid-frame");
    sendString("L000000011234");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_command",    64'(bus.command),    64'd0);
    checkOutput("midrst_address",    64'(bus.address),    64'd0);
    checkOutput("midrst_data",       64'(bus.data),       64'd0);
    checkOutput("midrst_data_count", 64'(bus.data_count), 64'd0);
    checkOutput("midrst_busy",       64'(bus.busy),       64'd0);
    word_buf[0] = 32'h0BADF00D;
    sendFrame(16'h0000, 16'h0007, 32'h00000004, 1'b0);

    $display("[TB] random frames");
    for (int f = 0; f < 4; f++) begin
      logic [15:0] cnt;
      cnt = 16'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) word_buf[i] = $urandom;
      sendFrame(cnt, 16'($urandom), $urandom, f[0]);
    end

    repeat (5) @(posedge clk);
    #1;
    checkOutput("final_scoreboard_empty", 64'(sb.size()), 64'd0);
    checkOutput("error_pulse_total",      64'(err_seen),  64'd2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
